// File: rtl/dc_pred_nch.sv
// DC intra predictor: sums the top/left edges LANES samples per beat per channel, rounds to
// one DC per channel and streams the flat block one row per beat. Optional counter: DC_PRED_CNT_EN.
module dc_pred_nch #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int CHANNELS   = 2,
    parameter int LANES      = 2,
    parameter int COORD_W    = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_valid,
    output logic                                   start_ready,
    input  logic [COORD_W-1:0]                     x,
    input  logic [COORD_W-1:0]                     y,
    input  logic [CHANNELS*BLOCK_SIZE*BIT_WIDTH-1:0] top,
    input  logic [CHANNELS*BLOCK_SIZE*BIT_WIDTH-1:0] left,
    output logic                                   dst_valid,
    input  logic                                   dst_ready,
    output logic [CHANNELS*BLOCK_SIZE*BIT_WIDTH-1:0] dst_row,
    output logic                                   dst_last,
    output logic [CHANNELS*BIT_WIDTH-1:0]          dc
`ifdef DC_PRED_CNT_EN
    ,
    output logic [15:0]                            blk_cnt
`endif
);

    localparam int K       = BLOCK_SIZE / LANES;
    localparam int LOG2_BS = $clog2(BLOCK_SIZE);
    localparam int SHIFT   = LOG2_BS + 1;
    localparam int ACC_W   = BIT_WIDTH + LOG2_BS + 1;
    localparam int CNT_W   = LOG2_BS + 1;
    localparam int EDGE_W  = CHANNELS * BLOCK_SIZE * BIT_WIDTH;

    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0]     LAST_ROW  = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [BIT_WIDTH-1:0] DC_NONE   = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                          has_top;
    logic                          has_left;
    logic [EDGE_W-1:0]             top_q;
    logic [EDGE_W-1:0]             left_q;
    logic [CNT_W-1:0]              beat;
    logic [CNT_W-1:0]              row;
    logic [ACC_W-1:0]              acc      [CHANNELS];
    logic [ACC_W-1:0]              beat_sum [CHANNELS];
    logic [CHANNELS*BIT_WIDTH-1:0] dc_q;
    logic                          dst_valid_q;
    logic                          dst_last_q;

    // A missing edge is replaced by the other one, so TOP/LEFT add 2x the available sample.
    function automatic logic [ACC_W-1:0] pair_sum(input logic [EDGE_W-1:0] t,
                                                  input logic [EDGE_W-1:0] l,
                                                  input logic ht, input logic hl, input int idx);
        logic [BIT_WIDTH-1:0] ts;
        logic [BIT_WIDTH-1:0] ls;
        ts = t[idx*BIT_WIDTH +: BIT_WIDTH];
        ls = l[idx*BIT_WIDTH +: BIT_WIDTH];
        return ACC_W'(ht ? ts : ls) + ACC_W'(hl ? ls : ts);
    endfunction

    assign start_ready = (state == IDLE);
    assign dst_valid   = dst_valid_q;
    assign dst_last    = dst_last_q;
    assign dc          = dc_q;

    // Every sample of a row carries its channel's DC.
    always_comb begin
        dst_row = {EDGE_W{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                dst_row[(c*BLOCK_SIZE+i)*BIT_WIDTH +: BIT_WIDTH] = dc_q[c*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Per-channel contribution of the current beat's LANES edge positions.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            beat_sum[c] = {ACC_W{1'b0}};
            for (int l = 0; l < LANES; l++) begin
                beat_sum[c] = beat_sum[c] + pair_sum(top_q, left_q, has_top, has_left,
                                                     c*BLOCK_SIZE + int'(beat)*LANES + l);
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    if ((|x) || (|y)) state_next = ACC;
                    else              state_next = DIV;
                end else begin
                    state_next = IDLE;
                end
            end
            ACC: begin
                if (beat == LAST_BEAT) state_next = DIV;
                else                   state_next = ACC;
            end
            DIV: state_next = OUT;
            OUT: begin
                if (dst_ready && (row == LAST_ROW)) state_next = IDLE;
                else                                state_next = OUT;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath: latch request, accumulate, divide, then walk the rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_top     <= 1'b0;
            has_left    <= 1'b0;
            top_q       <= {EDGE_W{1'b0}};
            left_q      <= {EDGE_W{1'b0}};
            beat        <= {CNT_W{1'b0}};
            row         <= {CNT_W{1'b0}};
            dc_q        <= {(CHANNELS*BIT_WIDTH){1'b0}};
            dst_valid_q <= 1'b0;
            dst_last_q  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) acc[c] <= {ACC_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        has_top  <= |y;
                        has_left <= |x;
                        top_q    <= top;
                        left_q   <= left;
                        beat     <= {CNT_W{1'b0}};
                        for (int c = 0; c < CHANNELS; c++) acc[c] <= {ACC_W{1'b0}};
                    end
                end
                ACC: begin
                    beat <= beat + CNT_W'(1);
                    for (int c = 0; c < CHANNELS; c++) acc[c] <= acc[c] + beat_sum[c];
                end
                DIV: begin
                    // acc + BLOCK_SIZE stays below 2^ACC_W, so no carry bit is needed.
                    for (int c = 0; c < CHANNELS; c++) begin
                        dc_q[c*BIT_WIDTH +: BIT_WIDTH] <= (has_top || has_left) ?
                            BIT_WIDTH'((acc[c] + ACC_W'(BLOCK_SIZE)) >> SHIFT) : DC_NONE;
                    end
                    dst_valid_q <= 1'b1;
                    dst_last_q  <= 1'b0;
                    row         <= {CNT_W{1'b0}};
                end
                OUT: begin
                    if (dst_ready) begin
                        if (row == LAST_ROW) begin
                            dst_valid_q <= 1'b0;
                            dst_last_q  <= 1'b0;
                            row         <= {CNT_W{1'b0}};
                        end else begin
                            row        <= row + CNT_W'(1);
                            dst_last_q <= (row == (LAST_ROW - CNT_W'(1)));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DC_PRED_CNT_EN
    // Completed-block counter, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= 16'h0000;
        end else if (dst_valid_q && dst_ready && dst_last_q && (blk_cnt != 16'hFFFF)) begin
            blk_cnt <= blk_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_dc_pred_nch.sv
// Scoreboard bench for dc_pred_nch: a stimulus process queues model DC values, a monitor
// process checks every delivered row. Define DC_PRED_CNT_EN to also check blk_cnt.
module tb_dc_pred_nch;

    localparam int BW = 8;
    localparam int BS = 8;
    localparam int CH = 2;
    localparam int LN = 2;
    localparam int CW = 10;
    localparam int K  = BS / LN;
    localparam int EW = CH * BS * BW;
    localparam int DW = CH * BW;

    logic          clk;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [EW-1:0] top;
    logic [EW-1:0] left;
    logic          dst_valid;
    logic          dst_ready;
    logic [EW-1:0] dst_row;
    logic          dst_last;
    logic [DW-1:0] dc;
`ifdef DC_PRED_CNT_EN
    logic [15:0]   blk_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int blocks_done = 0;
    int exp_done = 0;
    int exp_blk = 0;
    bit rand_ready = 1'b0;
    logic [DW-1:0] exp_q[$];

    dc_pred_nch #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .CHANNELS(CH), .LANES(LN), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .x(x), .y(y), .top(top), .left(left), .dst_valid(dst_valid), .dst_ready(dst_ready),
        .dst_row(dst_row), .dst_last(dst_last), .dc(dc)
`ifdef DC_PRED_CNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: DC = round(mean of the 2*BS edge samples), missing edge mirrored, none => mid-grey.
    function automatic logic [DW-1:0] model_dc(input bit xnz, input bit ynz,
                                               input logic [EW-1:0] t, input logic [EW-1:0] l);
        logic [DW-1:0] r;
        int st, sl, sum;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            st = 0;
            sl = 0;
            for (int i = 0; i < BS; i++) begin
                st += int'(t[(c*BS+i)*BW +: BW]);
                sl += int'(l[(c*BS+i)*BW +: BW]);
            end
            if (xnz && ynz)  sum = st + sl;
            else if (ynz)    sum = 2 * st;
            else if (xnz)    sum = 2 * sl;
            else             sum = -1;
            if (sum < 0) r[c*BW +: BW] = BW'(1 << (BW - 1));
            else         r[c*BW +: BW] = BW'((sum + BS) / (2 * BS));
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] replicate(input logic [DW-1:0] d);
        logic [EW-1:0] r;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < BS; i++) r[(c*BS+i)*BW +: BW] = d[c*BW +: BW];
        return r;
    endfunction

    function automatic logic [EW-1:0] fill(input logic [BW-1:0] v0, input logic [BW-1:0] v1);
        logic [EW-1:0] r;
        for (int i = 0; i < BS; i++) begin
            r[i*BW +: BW]      = v0;
            r[(BS+i)*BW +: BW] = v1;
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] rand_edge();
        logic [EW-1:0] r;
        bit sat;
        sat = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < CH*BS; i++) r[i*BW +: BW] = sat ? 8'hFF : BW'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) dst_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Issue one request, queue its expected DC, return once the first row is presented.
    task automatic issue(input logic [CW-1:0] xv, input logic [CW-1:0] yv,
                         input logic [EW-1:0] tv, input logic [EW-1:0] lv);
        int n;
        int lat;
        n = 0;
        while (!start_ready && n < 300) begin tick(); n++; end
        check("start_ready_wait", start_ready, 1'b1);
        x = xv; y = yv; top = tv; left = lv;
        start_valid = 1'b1;
        exp_q.push_back(model_dc(xv != 0, yv != 0, tv, lv));
        lat = ((xv != 0) || (yv != 0)) ? K + 2 : 2;
        tick();
        start_valid = 1'b0;
        x = CW'($urandom); y = CW'($urandom); top = rand_edge(); left = rand_edge();
        check("busy_after_accept", start_ready, 1'b0);
        n = 1;
        while (!dst_valid && n < 60) begin tick(); n++; end
        check("first_valid_latency", n, lat);
    endtask

    task automatic finish_block(output int n);
        n = 0;
        while (!start_ready && n < 300) begin tick(); n++; end
        check("block_done", start_ready, 1'b1);
        exp_done++;
        exp_blk++;
    endtask

    // Monitor: compares each accepted row against the queue head and checks stall stability.
    initial begin : monitor
        int row_i;
        bit stalled;
        logic [EW-1:0] held_row;
        logic [DW-1:0] held_dc;
        logic [DW-1:0] cur;
        row_i = 0;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                row_i = 0;
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", dst_valid, 1'b1);
                    check("stall_row", dst_row, held_row);
                    check("stall_dc", dc, held_dc);
                end
                stalled = 1'b0;
                if (dst_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_row: actual=%0h required=none", dst_row);
                    end else begin
                        cur = exp_q[0];
                        if (dst_ready) begin
                            check("row_data", dst_row, replicate(cur));
                            check("row_dc", dc, cur);
                            check("row_last", dst_last, (row_i == BS - 1));
                            if (row_i == BS - 1) begin
                                void'(exp_q.pop_front());
                                row_i = 0;
                                blocks_done++;
                            end else begin
                                row_i++;
                            end
                        end else begin
                            stalled  = 1'b1;
                            held_row = dst_row;
                            held_dc  = dc;
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        logic [EW-1:0] tv;
        logic [EW-1:0] held_row;
        logic [DW-1:0] held_dc;
        rst = 1'b1; start_valid = 1'b0; dst_ready = 1'b0;
        x = '0; y = '0; top = '0; left = '0;
        tick(); tick();
        check("rst_valid", dst_valid, 1'b0);
        check("rst_last", dst_last, 1'b0);
        check("rst_row", dst_row, '0);
        check("rst_dc", dc, '0);
        check("rst_start_ready", start_ready, 1'b1);
`ifdef DC_PRED_CNT_EN
        check("rst_blk_cnt", blk_cnt, 16'd0);
`endif
        rst = 1'b0;
        dst_ready = 1'b1;
        tick();

        // BOTH
        issue(10'd1, 10'd1, fill(8'd10, 8'd255), fill(8'd20, 8'd255));
        check("both_dc", dc, {8'd255, 8'd15});
        check("both_first_not_last", dst_last, 1'b0);
        finish_block(n);
        check("both_rows_back_to_back", n, BS);

        // TOP, left garbage ignored
        tv = fill(8'd0, 8'd100);
        for (int i = 0; i < BS; i++) tv[i*BW +: BW] = BW'(i);
        issue(10'd0, 10'd3, tv, fill(8'hFF, 8'hFF));
        check("top_dc", dc, {8'd100, 8'd4});
        finish_block(n);

        // LEFT
        issue(10'd5, 10'd0, rand_edge(), fill(8'd7, 8'd7));
        check("left_dc", dc, {8'd7, 8'd7});
        finish_block(n);
`ifdef DC_PRED_CNT_EN
        check("blk_cnt_three", blk_cnt, 16'd3);
`endif

        // NONE
        issue(10'd0, 10'd0, rand_edge(), rand_edge());
        check("none_dc", dc, {8'd128, 8'd128});
        finish_block(n);

        // Backpressure at row 2 with a start pulse while busy
        issue(10'd2, 10'd9, rand_edge(), rand_edge());
        tick(); tick();
        dst_ready = 1'b0;
        held_row = dst_row;
        held_dc = dc;
        start_valid = 1'b1; x = 10'd4; y = 10'd4;
        for (int i = 0; i < 3; i++) begin
            check("bp_start_ready", start_ready, 1'b0);
            check("bp_valid", dst_valid, 1'b1);
            check("bp_row", dst_row, held_row);
            check("bp_dc", dc, held_dc);
            tick();
        end
        start_valid = 1'b0;
        dst_ready = 1'b1;
        finish_block(n);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bp_no_extra_block", dst_valid, 1'b0);
        end

        // Reset mid-OUT at row 4
        issue(10'd3, 10'd3, rand_edge(), rand_edge());
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        void'(exp_q.pop_front());
        #1;
        check("midrst_valid", dst_valid, 1'b0);
        check("midrst_row", dst_row, '0);
        check("midrst_dc", dc, '0);
        check("midrst_last", dst_last, 1'b0);
`ifdef DC_PRED_CNT_EN
        check("midrst_blk_cnt", blk_cnt, 16'd0);
`endif
        exp_blk = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        issue(10'd7, 10'd1, fill(8'd50, 8'd200), fill(8'd61, 8'd3));
        check("after_rst_dc", dc, {8'd102, 8'd56});
        finish_block(n);

        // Random blocks under random backpressure
        rand_ready = 1'b1;
        for (int b = 0; b < 25; b++) begin
            logic [CW-1:0] xv;
            logic [CW-1:0] yv;
            xv = ($urandom_range(0, 2) == 0) ? 10'd0 : CW'($urandom_range(1, 1023));
            yv = ($urandom_range(0, 2) == 0) ? 10'd0 : CW'($urandom_range(1, 1023));
            issue(xv, yv, rand_edge(), rand_edge());
            finish_block(n);
        end
        rand_ready = 1'b0;
        dst_ready = 1'b1;
        tick(); tick();

        check("queue_drained", exp_q.size(), 0);
        check("blocks_delivered", blocks_done, exp_done);
`ifdef DC_PRED_CNT_EN
        check("blk_cnt_final", blk_cnt, exp_blk);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
